wr_req_target: RTL
==================

// Module: wr_req_target
// PURPOSE
//  Target-side endpoint for crossbar write requests (sel/addr/wdata/req bundle).
//  Accepts each request with a four-phase req/ack handshake and queues it in a small FIFO.
//  Drains the FIFO to a local memory/register write port that can apply backpressure.
//  Sits at each crossbar slave port, between the crossbar and the slave's storage.
// PARAMETERS
//  AWIDTH      32          address width
//  DWIDTH      32          write data width
//  MASTER_NUM  2           crossbar master count; SW = $clog2(MASTER_NUM)
//  FIFO_DEPTH  4           request queue depth, power of two, >=2
//  BASE_ADDR   32'h0       first valid address (used only with WR_REQ_TGT_ADDR_CHECK_EN)
//  ADDR_SPAN   32'h1000    count of valid addresses from BASE_ADDR (used only with the macro)
// PORTS
//  aclk        in   1          clock, rising edge
//  aresetn     in   1          asynchronous reset, active low
//  sel         in   SW         index of the originating master
//  addr        in   AWIDTH     write address
//  wdata       in   DWIDTH     write data
//  req         in   1          request level; initiator holds it and all fields stable until ack
//  ack         out  1          one-cycle acceptance pulse
//  ack_sel     out  SW         sel of the acked request; valid while ack=1
//  err         out  1          request rejected; valid while ack=1
//  mem_we      out  1          write strobe toward storage
//  mem_addr    out  AWIDTH     write address toward storage
//  mem_wdata   out  DWIDTH     write data toward storage
//  mem_src     out  SW         originating master of the current write
//  mem_ready   in   1          storage accepts the write when mem_we & mem_ready
//  fifo_level  out  clog2(FIFO_DEPTH)+1   number of queued entries
//  busy        out  1          high when FIFO is non-empty or FSM is not in IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, FIFO emptied, all outputs 0.
//  FSM states:
//   IDLE:     req=1 & !full at edge -> push {sel,addr,wdata}, ack=1 next cycle, go ACK.
//             req=1 & full -> stay in IDLE with no ack; initiator waits.
//   ACK:      ack high exactly one cycle; ack_sel=captured sel; go WAIT_LOW.
//   WAIT_LOW: stay until req=0 is sampled, then go IDLE. A new request needs req low for >=1 cycle.
//  Acceptance latency is 1 cycle: req sampled at edge T gives ack at T+1.
//  Minimum 4-cycle request period: accept, ACK, req low sampled, IDLE re-sample.
//  Drain: FIFO head is registered onto mem_* outputs.
//   Entry pushed at edge T -> mem_we=1 at T+1 at the earliest, if the FIFO was empty.
//   mem_we & !mem_ready -> mem_we, mem_addr, mem_wdata, mem_src hold stable.
//   mem_we & mem_ready -> pop; next entry is presented on the following cycle, or mem_we=0.
//   One write per cycle at most when the storage is always ready.
//  Push and pop in the same cycle leave fifo_level unchanged.
//  Full is evaluated on the pre-edge level; there is no bypass. A pop does not free space in the same edge.
//  FIFO pointers carry one extra wrap bit. full = MSBs differ and LSBs equal.
//  Write order to storage equals ack order.
//  A reset mid-transfer discards queued entries. Any in-flight ack or mem_we drops immediately.
// CONFIGURATION
//  Macro WR_REQ_TGT_ADDR_CHECK_EN:
//   Defined: in IDLE, addr outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) is acked with err=1 and not pushed.
//    The rejection is acked even when the FIFO is full.
//    In-range requests behave as above with err=0.
//   Undefined: no range check; err is tied to 0; BASE_ADDR and ADDR_SPAN are unused.
// STRUCTURE
//  Package wr_req_tgt_pkg:
//   tgt_state_e enum {IDLE, ACK, WAIT_LOW}.
//   Parameterised entry struct {src, addr, data}, or a width function for the packed entry.
//  Sub-module wr_req_tgt_fifo: synchronous FIFO with push/pop, full/empty, level and registered head.
//  Top module: handshake FSM, optional range check, and output registers.
// TESTING
//  1. Single write: req=1, sel=1, addr=0x10, wdata=0xA5A5 -> ack at +1 with ack_sel=1;
//     mem_we with 0x10/0xA5A5, mem_src=1, by +2.
//  2. Backpressure: mem_ready=0, issue 4 writes -> 4 acks, fifo_level=4;
//     5th req gets no ack until mem_ready=1 pops one.
//  3. Drain order: 3 queued writes (addr 0x0, 0x4, 0x8), mem_ready=1 -> three consecutive mem_we cycles in that order.
//  4. Handshake: req held high after ack -> no second ack until req is low for >=1 cycle.
//  5. Reset mid-operation: queued writes plus mem_we stalled, aresetn=0 -> ack, mem_we and busy drop at once, fifo_level=0.
//  6. With WR_REQ_TGT_ADDR_CHECK_EN, BASE=0x0, SPAN=0x1000: addr=0x2000 -> ack with err=1 and no mem_we;
//     addr=0xFFC -> err=0 and the write occurs.

Source files
------------

// File: rtl/wr_req_tgt_pkg.sv
// Shared types and width helpers for the crossbar write-request target.
package wr_req_tgt_pkg;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } tgt_state_e;

    // Master index width; a single-master crossbar still carries a 1-bit sel.
    function automatic int unsigned sel_width(input int unsigned master_num);
        return (master_num > 1) ? $clog2(master_num) : 1;
    endfunction

    // Packed queue entry is {src, addr, data}, src in the MSBs.
    function automatic int unsigned entry_width(input int unsigned sw, input int unsigned aw,
                                                input int unsigned dw);
        return sw + aw + dw;
    endfunction

endpackage

// File: rtl/wr_req_tgt_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word.
module wr_req_tgt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned PW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [AW-1:0]    rd_next_idx;
    logic             do_push, do_pop;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level       = wr_ptr_q - rd_ptr_q;
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign head        = head_q;

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Head follows whatever entry will sit at the read pointer after this edge.
    always_comb begin
        head_d = head_q;
        if (do_pop) begin
            if (level == PW'(1)) begin
                if (do_push) begin
                    head_d = push_data;
                end
            end else begin
                head_d = mem_q[rd_next_idx];
            end
        end else if (empty && do_push) begin
            head_d = push_data;
        end
    end

    // Pointers and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/wr_req_target.sv
// Crossbar write-request target: four-phase req/ack intake, request queue,
// and drain to a storage write port with backpressure.
// Optional address range check: define WR_REQ_TGT_ADDR_CHECK_EN.
module wr_req_target
    import wr_req_tgt_pkg::*;
#(
    parameter int unsigned        AWIDTH     = 32,
    parameter int unsigned        DWIDTH     = 32,
    parameter int unsigned        MASTER_NUM = 2,
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter logic [AWIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [AWIDTH-1:0]  ADDR_SPAN  = AWIDTH'(32'h1000),
    localparam int unsigned       SW         = sel_width(MASTER_NUM),
    localparam int unsigned       LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [SW-1:0]     sel,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              req,
    output logic              ack,
    output logic [SW-1:0]     ack_sel,
    output logic              err,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [SW-1:0]     mem_src,
    input  logic              mem_ready,
    output logic [LW-1:0]     fifo_level,
    output logic              busy
);

    localparam int unsigned EW = entry_width(SW, AWIDTH, DWIDTH);

    tgt_state_e    state_q, state_d;
    logic [SW-1:0] ack_sel_q, ack_sel_d;
    logic          err_q, err_d;
    logic          push, pop, full, empty, in_range;
    logic [EW-1:0] head;

`ifdef WR_REQ_TGT_ADDR_CHECK_EN
    logic [AWIDTH-1:0] addr_off;
    assign addr_off = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (addr_off < ADDR_SPAN);
`else
    assign in_range = 1'b1;
    // Range parameters only matter with the check enabled; keep them referenced.
    if (BASE_ADDR == ADDR_SPAN) begin : g_range_cfg_unused
    end
`endif

    wr_req_tgt_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push),
        .push_data ({sel, addr, wdata}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level),
        .head      (head)
    );

    // Handshake next-state: accept in IDLE, pulse ack once, then wait for req to drop.
    always_comb begin
        state_d   = state_q;
        ack_sel_d = ack_sel_q;
        err_d     = err_q;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        // Rejections never touch the queue, so full does not block them.
                        state_d   = ACK;
                        ack_sel_d = sel;
                        err_d     = 1'b1;
                    end else if (!full) begin
                        push      = 1'b1;
                        state_d   = ACK;
                        ack_sel_d = sel;
                        err_d     = 1'b0;
                    end
                end
            end
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Handshake state and captured ack fields.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            ack_sel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_sel_q <= ack_sel_d;
            err_q     <= err_d;
        end
    end

    assign ack     = (state_q == ACK);
    assign ack_sel = ack ? ack_sel_q : '0;
    assign err     = ack && err_q;

    // Storage side is driven straight from the queue head; it pops only on acceptance.
    assign mem_we                          = !empty;
    assign pop                             = mem_we && mem_ready;
    assign {mem_src, mem_addr, mem_wdata}  = head;
    assign busy                            = !empty || (state_q != IDLE);

endmodule
